serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: time-shares one 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_add_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

  localparam int MIN_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full-adder cell, time-shared by the serial adder controller.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first over WIDTH
// cycles, then presents a registered sum, carry-out and signed overflow.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < MIN_WIDTH) begin : g_width_check
    $error("serial_add_ctrl: WIDTH below minimum");
  end

  sa_state_t        r_state;
  sa_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [WIDTH-1:0] r_shs;
  logic [WIDTH-1:0] w_shs_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_fa_s;
  logic             w_fa_co;
  logic             w_last;

  full_adder_bit u_fa (
    .a    (r_sha[0]),
    .b    (r_shb[0]),
    .cin  (r_carry),
    .s    (w_fa_s),
    .cout (w_fa_co)
  );

  assign w_last    = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_shs_nxt = {w_fa_s, r_shs[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Results are written on the edge entering DONE so they are valid while done=1;
  // r_carry still holds the carry into the MSB on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sha   <= '0;
      r_shb   <= '0;
      r_shs   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sha   <= a;
            r_shb   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sha   <= {1'b0, r_sha[WIDTH-1:1]};
          r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
          r_shs   <= w_shs_nxt;
          r_carry <= w_fa_co;
          if (w_last) begin
            r_cnt  <= '0;
            r_sum  <= w_shs_nxt;
            r_cout <= w_fa_co;
            r_ovf  <= r_carry ^ w_fa_co;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE, runs one add, checks latency and results, leaves DUT back in IDLE.
  task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [7:0] es, input logic eco, input logic eov);
    int lat;
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 9);
    check_eq({tag, "_sum"}, sum, es);
    check_eq({tag, "_cout"}, cout, eco);
    check_eq({tag, "_ovf"}, overflow, eov);
    tick();
  endtask

  initial begin
    int done_cnt;
    int busy_gap;
    int gap;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] full;
    logic       rov;

    reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_sum", sum, 8'h00);
    check_eq("rst_cout", cout, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);

    run_add("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    check_eq("t1_pulse", done, 1'b0);
    run_add("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("t3a", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    run_add("t3b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Test 4: start pulse with new operands in the middle of a run
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0; busy_gap = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) begin
        a = 8'hFF; b = 8'hFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check_eq("t4_sum", sum, 8'h46);
      end
      if (i <= 9 && !busy) busy_gap++;
      tick();
    end
    check_eq("t4_done_cnt", done_cnt, 1);
    check_eq("t4_busy_gap", busy_gap, 0);
    check_eq("t4_sum_hold", sum, 8'h46);

    // Test 5: reset in RUN cycle 4 discards the add
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_done", done, 1'b0);
    check_eq("t5_sum", sum, 8'h00);
    check_eq("t5_cout", cout, 1'b0);
    check_eq("t5_ovf", overflow, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check_eq("t5_no_done", done_cnt, 0);

    // Test 6: start held high, back-to-back adds every WIDTH+2 cycles
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    gap = 0;
    while (!done && gap < 30) begin
      tick();
      gap++;
    end
    check_eq("t6_first", done, 1'b1);
    check_eq("t6_sum0", sum, 8'h02);
    for (int p = 0; p < 3; p++) begin
      gap = 0;
      tick();
      gap++;
      while (!done && gap < 30) begin
        check_eq("t6_stable", sum, 8'h02);
        tick();
        gap++;
      end
      check_eq("t6_period", gap, 10);
      check_eq("t6_sum", sum, 8'h02);
    end
    start = 1'b0;
    tick();

    for (int v = 0; v < 1000; v++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      rov = (ra[7] == rb[7]) && (full[7] != ra[7]);
      run_add("rnd", ra, rb, rc, full[7:0], full[8], rov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
